// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side is the byte source plus the memory; the slave side is the loader.
interface imem_program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them sequentially
// into instruction memory, holding the core in reset until the load completes.
module imem_program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 512
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  num_words,
    imem_program_loader_if.slave         bus,
    output logic                         cpu_hold,
    output logic                         done,
    output logic                         err,
    output logic [15:0]                  word_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [1:0]  byte_idx_reg;
    logic [23:0] byte_buf_reg;
    logic [15:0] num_words_reg;
    logic [15:0] word_count_reg;
    logic        err_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;

    logic        start_ok;
    logic        reject;
    logic        accept;
    logic        word_full;
    logic        last_word;

    assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign reject    = 32'(num_words) > MAX_WORDS;
    assign accept    = bus.byte_valid && bus.byte_ready;
    assign word_full = accept && (byte_idx_reg == 2'd3);
    // word_count_reg still indexes the word being filled: it only advances
    // on the write strobe, which lands well before the next word completes.
    assign last_word = ({1'b0, word_count_reg} + 17'd1) == {1'b0, num_words_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    if ((num_words == 16'd0) || reject) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_full && last_word) begin
                    state_next = FINISH;
                end
            end
            FINISH: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.byte_ready = (state_reg == LOAD);
        done           = (state_reg == DONE) && !err_reg;
        err            = (state_reg == DONE) && err_reg;
        // A rejected load leaves the core held.
        cpu_hold       = !((state_reg == DONE) && !err_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_reg   <= 2'd0;
            byte_buf_reg   <= 24'd0;
            num_words_reg  <= 16'd0;
            word_count_reg <= 16'd0;
            err_reg        <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= BASE_ADDR;
            mem_wdata_reg  <= 32'd0;
        end else begin
            mem_we_reg <= word_full;
            if (accept) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                byte_buf_reg <= {byte_buf_reg[15:0], bus.byte_data};
            end
            if (word_full) begin
                mem_wdata_reg <= {byte_buf_reg, bus.byte_data};
                mem_addr_reg  <= BASE_ADDR + {14'd0, word_count_reg, 2'b00};
            end
            if (mem_we_reg) begin
                word_count_reg <= word_count_reg + 16'd1;
            end
            if (start_ok) begin
                byte_idx_reg   <= 2'd0;
                byte_buf_reg   <= 24'd0;
                word_count_reg <= 16'd0;
                num_words_reg  <= num_words;
                err_reg        <= reject;
            end
        end
    end

    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign word_count    = word_count_reg;

endmodule

// File: tb/tb_imem_program_loader.sv
// Two loaders (base 0x0 and 0x100) fed the same stream; a scoreboard of expected
// writes is filled by the driver and drained by a per-DUT write monitor.
module tb_imem_program_loader;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        cpu_hold0, done0, err0;
    logic        cpu_hold1, done1, err1;
    logic [15:0] wc0, wc1;

    imem_program_loader_if bus0();
    imem_program_loader_if bus1();

    assign bus0.byte_valid = byte_valid;
    assign bus0.byte_data  = byte_data;
    assign bus1.byte_valid = byte_valid;
    assign bus1.byte_data  = byte_data;

    imem_program_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(512)) dut0 (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words), .bus(bus0),
        .cpu_hold(cpu_hold0), .done(done0), .err(err0), .word_count(wc0)
    );

    imem_program_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(512)) dut1 (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words), .bus(bus1),
        .cpu_hold(cpu_hold1), .done(done1), .err(err1), .word_count(wc1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          w;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  stim_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          nbytes = 0;
    logic [31:0] cur_word = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic [31:0] addr, input logic [31:0] data,
                       input logic [15:0] wc);
        exp_t        e;
        logic [31:0] base;
        bit          empty;
        base  = (id == 0) ? BASE0 : BASE1;
        empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
        $display("write dut%0d addr=%h data=%h word_count=%0d", id, addr, data, wc);
        if (empty) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write dut%0d: actual addr=%h data=%h required no write",
                     id, addr, data);
        end else begin
            if (id == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            chk($sformatf("wr_addr_dut%0d", id), addr, base + 32'(e.w) * 32'd4);
            chk($sformatf("wr_data_dut%0d", id), data, e.data);
            chk($sformatf("wr_count_dut%0d", id), {16'd0, wc}, 32'(e.w));
        end
    endtask

    always @(negedge clk) begin
        if (bus0.mem_we) mon(0, bus0.mem_addr, bus0.mem_wdata, wc0);
        if (bus1.mem_we) mon(1, bus1.mem_addr, bus1.mem_wdata, wc1);
    end

    task automatic check_reset(input string tag);
        chk({tag, "_ready0"}, {31'd0, bus0.byte_ready}, 32'd0);
        chk({tag, "_we0"},    {31'd0, bus0.mem_we}, 32'd0);
        chk({tag, "_addr0"},  bus0.mem_addr, BASE0);
        chk({tag, "_addr1"},  bus1.mem_addr, BASE1);
        chk({tag, "_wdata0"}, bus0.mem_wdata, 32'd0);
        chk({tag, "_hold0"},  {31'd0, cpu_hold0}, 32'd1);
        chk({tag, "_done0"},  {31'd0, done0}, 32'd0);
        chk({tag, "_err0"},   {31'd0, err0}, 32'd0);
        chk({tag, "_wc0"},    {16'd0, wc0}, 32'd0);
        chk({tag, "_wc1"},    {16'd0, wc1}, 32'd0);
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_words = 16'(n);
        @(posedge clk); #1;
        start    = 1'b0;
        nbytes   = 0;
        cur_word = 32'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit   ok;
        logic rdy;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            rdy = bus0.byte_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: actual not accepted in 50 cycles required accepted");
        end else begin
            // Reference packing: each group of four bytes forms one word, first byte on top.
            cur_word = {cur_word[23:0], b};
            nbytes++;
            if (nbytes % 4 == 0) begin
                q0.push_back('{w: nbytes / 4 - 1, data: cur_word});
                q1.push_back('{w: nbytes / 4 - 1, data: cur_word});
            end
        end
    endtask

    // gapmode: 0 back-to-back, 1 valid every other cycle, 2 random idle cycles
    task automatic load(input int n, input int gapmode, input bit poke, input bit use_stim);
        logic [7:0] b;
        int         gap;
        do_start(n);
        for (int i = 0; i < 4 * n; i++) begin
            b   = use_stim ? stim_q[i] : 8'($urandom);
            gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(2, 0));
            if (poke && i == 5) begin
                start     = 1'b1;
                num_words = 16'(n + 3);
            end
            send_byte(b, gap);
            start = 1'b0;
        end
        byte_valid = 1'b0;
        @(negedge clk);
        chk("finish_done0", {31'd0, done0}, 32'd0);
        chk("finish_hold0", {31'd0, cpu_hold0}, 32'd1);
        chk("finish_ready0", {31'd0, bus0.byte_ready}, 32'd0);
        @(negedge clk);
        chk("done0", {31'd0, done0}, 32'd1);
        chk("done1", {31'd0, done1}, 32'd1);
        chk("done_hold0", {31'd0, cpu_hold0}, 32'd0);
        chk("done_err0", {31'd0, err0}, 32'd0);
        chk("done_wc0", {16'd0, wc0}, 32'(n));
        chk("done_wc1", {16'd0, wc1}, 32'(n));
        chk("drained0", 32'(q0.size()), 32'd0);
        chk("drained1", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual simulation still running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        num_words  = 16'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Zero-length load from IDLE
        do_start(0);
        @(negedge clk);
        chk("zero_done0", {31'd0, done0}, 32'd1);
        chk("zero_hold0", {31'd0, cpu_hold0}, 32'd0);
        chk("zero_wc0", {16'd0, wc0}, 32'd0);

        // Known two-word program, back-to-back then with valid toggling
        stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
        load(2, 0, 1'b0, 1'b1);
        chk("t1_last_addr0", bus0.mem_addr, 32'h0000_0004);
        chk("t1_last_data0", bus0.mem_wdata, 32'hAC09_0000);
        load(2, 1, 1'b0, 1'b1);

        // Oversized request is rejected and offered bytes are not consumed
        do_start(513);
        @(negedge clk);
        chk("rej_err0", {31'd0, err0}, 32'd1);
        chk("rej_done0", {31'd0, done0}, 32'd0);
        chk("rej_hold0", {31'd0, cpu_hold0}, 32'd1);
        chk("rej_ready0", {31'd0, bus0.byte_ready}, 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (4) @(posedge clk);
        #1 byte_valid = 1'b0;
        chk("rej_wc0", {16'd0, wc0}, 32'd0);
        chk("max_ok_err0", {31'd0, err0}, 32'd1);

        // Restart out of the rejected DONE with a zero-length load
        do_start(0);
        @(negedge clk);
        chk("restart_err0", {31'd0, err0}, 32'd0);
        chk("restart_done0", {31'd0, done0}, 32'd1);

        // Reset partway through the second word
        do_start(2);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 0);
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load(1, 0, 1'b0, 1'b1);
        chk("midrst_addr0", bus0.mem_addr, BASE0);
        chk("midrst_data0", bus0.mem_wdata, 32'hDEAD_BEEF);

        // Three words with start raised mid-load, then a maximum-size boundary load
        load(3, 2, 1'b1, 1'b0);
        chk("t6_last_addr1", bus1.mem_addr, 32'h0000_0108);
        load(512, 0, 1'b0, 1'b0);
        chk("max_last_addr0", bus0.mem_addr, 32'h0000_07FC);

        for (int r = 0; r < 12; r++) begin
            int n;
            n = int'($urandom_range(6, 1));
            load(n, int'($urandom_range(2, 0)), (n >= 2) && ($urandom_range(1, 0) == 1), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("final_drained0", 32'(q0.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
